enemy_ctrl: RTL and testbench

Game-logic stage directly upstream of enemy_render. It owns one enemy's lifecycle and produces the state, x_me and y_me that enemy_render consumes, replacing today's constant ALIVE/(100,50) tie-offs. It bounces the enemy around the screen, hit-tests rising edges of the PS/2 left button against the scaled mouse position, and counts a saturating score for the HEX display.

---
 rtl/enemy_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_enemy_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_ctrl.sv
// Single-enemy game logic: bounces the sprite, hit-tests mouse clicks, runs the
// DYING/DEAD/respawn lifecycle and keeps a saturating score for the HEX display.
module enemy_ctrl #(
    parameter int unsigned STEP_DIV      = 833333,
    parameter int unsigned SPRITE_W      = 32,
    parameter int unsigned SPRITE_H      = 32,
    parameter int unsigned X_MIN         = 16,
    parameter int unsigned X_MAX         = 592,
    parameter int unsigned Y_MIN         = 16,
    parameter int unsigned Y_MAX         = 432,
    parameter int unsigned SPEED         = 2,
    parameter int unsigned DYING_TICKS   = 30,
    parameter int unsigned RESPAWN_TICKS = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       shot,
    input  logic [9:0] mouse_x,
    input  logic [8:0] mouse_y,
    output logic [1:0] state,
    output logic [9:0] x_me,
    output logic [8:0] y_me,
    output logic       hit,
    output logic [13:0] score
);

    localparam int unsigned CNT_W   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned TMR_MAX = (DYING_TICKS > RESPAWN_TICKS) ? DYING_TICKS : RESPAWN_TICKS;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(STEP_DIV - 1);
    localparam logic [TMR_W-1:0] TMR_DYING   = TMR_W'(DYING_TICKS);
    localparam logic [TMR_W-1:0] TMR_RESPAWN = TMR_W'(RESPAWN_TICKS);
    localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(1);
    localparam logic [13:0]      SCORE_MAX   = 14'd9999;
    localparam logic [15:0]      LFSR_SEED   = 16'hACE1;
    localparam logic [15:0]      LFSR_TAPS   = 16'hB400;

    localparam logic [9:0] X_MIN_V = 10'(X_MIN);
    localparam logic [9:0] X_MAX_V = 10'(X_MAX);
    localparam logic [8:0] Y_MIN_V = 9'(Y_MIN);
    localparam logic [8:0] Y_MAX_V = 9'(Y_MAX);

    localparam logic signed [11:0] SPEED_S = 12'(SPEED);
    localparam logic signed [11:0] X_MIN_S = 12'(X_MIN);
    localparam logic signed [11:0] X_MAX_S = 12'(X_MAX);
    localparam logic signed [11:0] Y_MIN_S = 12'(Y_MIN);
    localparam logic signed [11:0] Y_MAX_S = 12'(Y_MAX);

    typedef enum logic [1:0] {
        ST_DEAD  = 2'd0,
        ST_ALIVE = 2'd1,
        ST_DYING = 2'd2
    } state_t;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        logic [15:0] shifted;
        shifted = {1'b0, cur[15:1]};
        return cur[0] ? (shifted ^ LFSR_TAPS) : shifted;
    endfunction

    function automatic logic [13:0] score_inc(input logic [13:0] cur);
        return (cur >= SCORE_MAX) ? SCORE_MAX : (cur + 14'd1);
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [9:0]       x_q, x_d;
    logic [8:0]       y_q, y_d;
    logic             dx_neg_q, dx_neg_d;
    logic             dy_neg_q, dy_neg_d;
    logic [15:0]      lfsr_q;
    logic             shot_q;
    logic             hit_q, hit_d;
    logic [13:0]      score_q, score_d;

    logic             tick_s;
    logic             fire_s;
    logic             inside_s;
    logic             timer_last_s;
    logic [10:0]      x_hi_s;
    logic [9:0]       y_hi_s;
    logic signed [11:0] x_ext_s, y_ext_s;
    logic signed [11:0] nx_s, ny_s;
    logic [9:0]       x_step_s;
    logic [8:0]       y_step_s;
    logic             dx_step_s, dy_step_s;

    // Free-running game-tick divider.
    always_comb begin
        if (cnt_q == CNT_LAST) begin
            tick_s = 1'b1;
            cnt_d  = '0;
        end else begin
            tick_s = 1'b0;
            cnt_d  = cnt_q + 1'b1;
        end
    end

    // Click edge detect and hitbox test; upper bounds carry an extra bit so they never wrap.
    always_comb begin
        fire_s       = shot & ~shot_q;
        x_hi_s       = {1'b0, x_q} + 11'(SPRITE_W - 1);
        y_hi_s       = {1'b0, y_q} + 10'(SPRITE_H - 1);
        inside_s     = (mouse_x >= x_q) && ({1'b0, mouse_x} <= x_hi_s) &&
                       (mouse_y >= y_q) && ({1'b0, mouse_y} <= y_hi_s);
        timer_last_s = (timer_q == TMR_ONE);
    end

    // Candidate bounce step; clamping onto a wall is what reverses direction.
    always_comb begin
        x_ext_s = $signed({2'b00, x_q});
        y_ext_s = $signed({3'b000, y_q});
        nx_s    = dx_neg_q ? (x_ext_s - SPEED_S) : (x_ext_s + SPEED_S);
        ny_s    = dy_neg_q ? (y_ext_s - SPEED_S) : (y_ext_s + SPEED_S);

        if (nx_s > X_MAX_S) begin
            x_step_s  = X_MAX_V;
            dx_step_s = 1'b1;
        end else if (nx_s < X_MIN_S) begin
            x_step_s  = X_MIN_V;
            dx_step_s = 1'b0;
        end else begin
            x_step_s  = nx_s[9:0];
            dx_step_s = dx_neg_q;
        end

        if (ny_s > Y_MAX_S) begin
            y_step_s  = Y_MAX_V;
            dy_step_s = 1'b1;
        end else if (ny_s < Y_MIN_S) begin
            y_step_s  = Y_MIN_V;
            dy_step_s = 1'b0;
        end else begin
            y_step_s  = ny_s[8:0];
            dy_step_s = dy_neg_q;
        end
    end

    // Lifecycle FSM next-state logic.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        x_d      = x_q;
        y_d      = y_q;
        dx_neg_d = dx_neg_q;
        dy_neg_d = dy_neg_q;
        hit_d    = 1'b0;
        score_d  = score_q;

        case (state_q)
            ST_DEAD: begin
                if (tick_s && timer_last_s) begin
                    state_d  = ST_ALIVE;
                    x_d      = X_MIN_V + {1'b0, lfsr_q[8:0]};
                    y_d      = Y_MIN_V + {1'b0, lfsr_q[15:8]};
                    dx_neg_d = lfsr_q[15];
                    dy_neg_d = lfsr_q[0];
                end else if (tick_s) begin
                    timer_d = timer_q - 1'b1;
                end else begin
                    timer_d = timer_q;
                end
            end
            ST_ALIVE: begin
                if (fire_s && inside_s) begin
                    state_d = ST_DYING;
                    timer_d = TMR_DYING;
                    hit_d   = 1'b1;
                    score_d = score_inc(score_q);
                end else if (tick_s) begin
                    x_d      = x_step_s;
                    y_d      = y_step_s;
                    dx_neg_d = dx_step_s;
                    dy_neg_d = dy_step_s;
                end else begin
                    x_d = x_q;
                end
            end
            ST_DYING: begin
                if (tick_s && timer_last_s) begin
                    state_d = ST_DEAD;
                    timer_d = TMR_RESPAWN;
                end else if (tick_s) begin
                    timer_d = timer_q - 1'b1;
                end else begin
                    timer_d = timer_q;
                end
            end
            default: begin
                state_d = ST_DEAD;
                timer_d = TMR_RESPAWN;
            end
        endcase
    end

    // State and output registers; the LFSR advances every cycle in every state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_DEAD;
            cnt_q    <= '0;
            timer_q  <= TMR_RESPAWN;
            x_q      <= X_MIN_V;
            y_q      <= Y_MIN_V;
            dx_neg_q <= 1'b0;
            dy_neg_q <= 1'b0;
            lfsr_q   <= LFSR_SEED;
            shot_q   <= 1'b0;
            hit_q    <= 1'b0;
            score_q  <= 14'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            timer_q  <= timer_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dx_neg_q <= dx_neg_d;
            dy_neg_q <= dy_neg_d;
            lfsr_q   <= lfsr_next(lfsr_q);
            shot_q   <= shot;
            hit_q    <= hit_d;
            score_q  <= score_d;
        end
    end

    assign state = state_q;
    assign x_me  = x_q;
    assign y_me  = y_q;
    assign hit   = hit_q;
    assign score = score_q;

endmodule

// File: tb/tb_enemy_ctrl.sv
// Directed bench for enemy_ctrl: vector table for reset/respawn/hit/phase timing,
// then hand sequences for held button, bounce, score saturation and async reset.
module tb_enemy_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        shot = 1'b0;
    logic [9:0]  mouse_x = 10'd0;
    logic [8:0]  mouse_y = 9'd0;
    logic [1:0]  state;
    logic [9:0]  x_me;
    logic [8:0]  y_me;
    logic        hit;
    logic [13:0] score;

    enemy_ctrl #(
        .STEP_DIV(4),
        .DYING_TICKS(2),
        .RESPAWN_TICKS(3),
        .SPEED(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .shot(shot),
        .mouse_x(mouse_x),
        .mouse_y(mouse_y),
        .state(state),
        .x_me(x_me),
        .y_me(y_me),
        .hit(hit),
        .score(score)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        shot;
        logic [9:0]  mx;
        logic [8:0]  my;
        logic [1:0]  st;
        logic [9:0]  x;
        logic [8:0]  y;
        logic        hit;
        logic [13:0] score;
    } vec_t;

    vec_t        vecs [1:39];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [15:0] lfsr_m = 16'hACE1;
    logic [15:0] lfsr_pre = 16'hACE1;

    function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
        logic [15:0] s;
        s = {1'b0, v[15:1]};
        return v[0] ? (s ^ 16'hB400) : s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: remembers the LFSR value the DUT uses at this edge, then samples #1 later.
    task automatic step();
        lfsr_pre = lfsr_m;
        @(posedge clk);
        lfsr_m = lfsr_adv(lfsr_m);
        cyc++;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned ex, ey, n_dying, n_dead, frozen_bad, score_bad;
        int          mx, my, mdx, mdy, nx, ny, px, py;
        int          pos_bad, bound_bad, rule_bad, hit_bad, saw_xmax, saw_xmin, wait_n;

        // Vector table: edges 1..39 after reset release (ticks on every 4th edge).
        for (int k = 1; k <= 39; k++) begin
            vecs[k].shot = 1'b0;
            vecs[k].mx   = 10'd0;
            vecs[k].my   = 9'd0;
            vecs[k].hit  = (k == 20);
            if (k < 12) begin
                vecs[k].st = 2'd0; vecs[k].x = 10'd16; vecs[k].y = 9'd16; vecs[k].score = 14'd0;
            end else if (k < 16) begin
                vecs[k].st = 2'd1; vecs[k].x = 10'd104; vecs[k].y = 9'd188; vecs[k].score = 14'd0;
            end else if (k < 20) begin
                vecs[k].st = 2'd1; vecs[k].x = 10'd100; vecs[k].y = 9'd192; vecs[k].score = 14'd0;
            end else if (k < 28) begin
                vecs[k].st = 2'd2; vecs[k].x = 10'd100; vecs[k].y = 9'd192; vecs[k].score = 14'd1;
            end else begin
                vecs[k].st = 2'd0; vecs[k].x = 10'd100; vecs[k].y = 9'd192; vecs[k].score = 14'd1;
            end
            if (k >= 20 && k != 26 && k != 32) begin
                vecs[k].shot = 1'b1; vecs[k].mx = 10'd100; vecs[k].my = 9'd223;
            end
        end
        vecs[2].shot  = 1'b1; vecs[2].mx  = 10'd16;  vecs[2].my  = 9'd16;
        vecs[13].shot = 1'b1; vecs[13].mx = 10'd136; vecs[13].my = 9'd188;
        vecs[15].shot = 1'b1; vecs[15].mx = 10'd104; vecs[15].my = 9'd220;
        vecs[19].mx   = 10'd100; vecs[19].my = 9'd223;

        #2 reset = 1'b0;
        #10;
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_x", {22'd0, x_me}, 32'd16);
        chk("rst_y", {23'd0, y_me}, 32'd16);
        chk("rst_hit", {31'd0, hit}, 32'd0);
        chk("rst_score", {18'd0, score}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int k = 1; k <= 39; k++) begin
            shot = vecs[k].shot; mouse_x = vecs[k].mx; mouse_y = vecs[k].my;
            step();
            chk($sformatf("vec%0d_state", k), {30'd0, state}, {30'd0, vecs[k].st});
            chk($sformatf("vec%0d_x", k), {22'd0, x_me}, {22'd0, vecs[k].x});
            chk($sformatf("vec%0d_y", k), {23'd0, y_me}, {23'd0, vecs[k].y});
            chk($sformatf("vec%0d_hit", k), {31'd0, hit}, {31'd0, vecs[k].hit});
            chk($sformatf("vec%0d_score", k), {18'd0, score}, {18'd0, vecs[k].score});
            if (k == 12) begin
                chk("respawn1_x_model", {22'd0, x_me}, 32'd16 + {23'd0, lfsr_pre[8:0]});
                chk("respawn1_y_model", {23'd0, y_me}, 32'd16 + {24'd0, lfsr_pre[15:8]});
            end
        end

        // Held button across respawn: mouse parked on the new position, no hit until re-press.
        step();
        ex = 16 + lfsr_pre[8:0];
        ey = 16 + lfsr_pre[15:8];
        chk("respawn2_state", {30'd0, state}, 32'd1);
        chk("respawn2_x", {22'd0, x_me}, ex);
        chk("respawn2_y", {23'd0, y_me}, ey);
        mouse_x = 10'(ex + 5);
        mouse_y = 9'(ey + 5);
        step();
        chk("held_hit_41", {31'd0, hit}, 32'd0);
        step();
        chk("held_hit_42", {31'd0, hit}, 32'd0);
        chk("held_state_42", {30'd0, state}, 32'd1);
        shot = 1'b0;
        step();
        shot = 1'b1;
        step();
        chk("repress_hit", {31'd0, hit}, 32'd1);
        chk("repress_state", {30'd0, state}, 32'd2);
        chk("repress_score", {18'd0, score}, 32'd2);
        chk("repress_x", {22'd0, x_me}, ex);

        // Phase timing with shot toggling every cycle.
        n_dying = 1; n_dead = 0; frozen_bad = 0; score_bad = 0;
        for (int i = 0; i < 20; i++) begin
            shot = ~shot;
            step();
            if (x_me != 10'(ex) || y_me != 9'(ey)) frozen_bad++;
            if (score != 14'd2 || hit != 1'b0) score_bad++;
            if (state == 2'd2) n_dying++;
            else break;
        end
        if (state == 2'd0) n_dead = 1;
        for (int i = 0; i < 20 && state == 2'd0; i++) begin
            shot = ~shot;
            step();
            if (state == 2'd0) begin
                n_dead++;
                if (x_me != 10'(ex) || y_me != 9'(ey)) frozen_bad++;
            end
            if (score != 14'd2 || hit != 1'b0) score_bad++;
        end
        chk("dying_cycles", n_dying, 32'd8);
        chk("dead_cycles", n_dead, 32'd12);
        chk("phase_pos_frozen", frozen_bad, 32'd0);
        chk("phase_fire_ignored", score_bad, 32'd0);
        chk("respawn3_state", {30'd0, state}, 32'd1);
        chk("respawn3_x", {22'd0, x_me}, 32'd16 + {23'd0, lfsr_pre[8:0]});
        chk("respawn3_y", {23'd0, y_me}, 32'd16 + {24'd0, lfsr_pre[15:8]});

        // Bounce for 300 ticks against a motion model seeded from the respawn LFSR.
        mx = 16 + lfsr_pre[8:0]; my = 16 + lfsr_pre[15:8];
        mdx = lfsr_pre[15] ? -4 : 4; mdy = lfsr_pre[0] ? -4 : 4;
        shot = 1'b0; mouse_x = 10'd0; mouse_y = 9'd0;
        pos_bad = 0; bound_bad = 0; rule_bad = 0; hit_bad = 0; saw_xmax = 0; saw_xmin = 0;
        for (int i = 0; i < 1200; i++) begin
            px = mx; py = my;
            step();
            if (cyc % 4 == 0) begin
                nx = mx + mdx;
                if (nx > 592) begin mx = 592; mdx = -4; end
                else if (nx < 16) begin mx = 16; mdx = 4; end
                else mx = nx;
                ny = my + mdy;
                if (ny > 432) begin my = 432; mdy = -4; end
                else if (ny < 16) begin my = 16; mdy = 4; end
                else my = ny;
                if (!(int'(x_me) - px == 4 || px - int'(x_me) == 4 || x_me == 10'd16 || x_me == 10'd592)) rule_bad++;
                if (!(int'(y_me) - py == 4 || py - int'(y_me) == 4 || y_me == 9'd16 || y_me == 9'd432)) rule_bad++;
            end
            if (int'(x_me) != mx || int'(y_me) != my) pos_bad++;
            if (x_me < 10'd16 || x_me > 10'd592 || y_me < 9'd16 || y_me > 9'd432) bound_bad++;
            if (hit != 1'b0 || state != 2'd1) hit_bad++;
            if (x_me == 10'd592) saw_xmax = 1;
            if (x_me == 10'd16) saw_xmin = 1;
        end
        chk("bounce_model_pos", pos_bad, 32'd0);
        chk("bounce_bounds", bound_bad, 32'd0);
        chk("bounce_step_rule", rule_bad, 32'd0);
        chk("bounce_no_hit", hit_bad, 32'd0);
        chk("bounce_reach_xmax", saw_xmax, 32'd1);
        chk("bounce_reach_xmin", saw_xmin, 32'd1);

        // Score saturation from a preloaded 9998.
        dut.score_q = 14'd9998;
        mouse_x = x_me + 10'd16; mouse_y = y_me + 9'd16; shot = 1'b1;
        step();
        chk("sat1_hit", {31'd0, hit}, 32'd1);
        chk("sat1_score", {18'd0, score}, 32'd9999);
        shot = 1'b0;
        step();
        chk("sat1_hit_pulse", {31'd0, hit}, 32'd0);
        wait_n = 0;
        while (state != 2'd1 && wait_n < 40) begin
            step();
            wait_n++;
        end
        chk("sat_wait_alive", {30'd0, state}, 32'd1);
        mouse_x = x_me + 10'd16; mouse_y = y_me + 9'd16; shot = 1'b1;
        step();
        chk("sat2_hit", {31'd0, hit}, 32'd1);
        chk("sat2_score", {18'd0, score}, 32'd9999);
        chk("sat2_state", {30'd0, state}, 32'd2);

        // Asynchronous reset in DYING, no clock edge in between.
        #2 reset = 1'b0;
        #1;
        chk("async_state", {30'd0, state}, 32'd0);
        chk("async_score", {18'd0, score}, 32'd0);
        chk("async_hit", {31'd0, hit}, 32'd0);
        chk("async_x", {22'd0, x_me}, 32'd16);
        chk("async_y", {23'd0, y_me}, 32'd16);
        @(negedge clk);
        reset = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
